// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field positions, exception codes
// and helpers that pack the architectural register views.
package cp0_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned INT_W = 6;
    localparam int unsigned EXC_W = 5;
    localparam int unsigned ADR_W = 5;

    localparam logic [ADR_W-1:0] REG_SR    = 5'd12;
    localparam logic [ADR_W-1:0] REG_CAUSE = 5'd13;
    localparam logic [ADR_W-1:0] REG_EPC   = 5'd14;
    localparam logic [ADR_W-1:0] REG_PRID  = 5'd15;

    localparam int unsigned SR_IM_LSB  = 10;
    localparam int unsigned SR_EXL_BIT = 1;
    localparam int unsigned SR_IE_BIT  = 0;
    localparam int unsigned CA_BD_BIT  = 31;
    localparam int unsigned CA_IP_LSB  = 10;
    localparam int unsigned CA_EXC_LSB = 2;

    typedef enum logic [EXC_W-1:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [XLEN-1:0] sr_pack(input logic [INT_W-1:0] im,
                                                input logic exl, input logic ie);
        logic [XLEN-1:0] v;
        v = '0;
        v[SR_IM_LSB +: INT_W] = im;
        v[SR_EXL_BIT]         = exl;
        v[SR_IE_BIT]          = ie;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] cause_pack(input logic bd,
                                                   input logic [INT_W-1:0] ip,
                                                   input logic [EXC_W-1:0] code);
        logic [XLEN-1:0] v;
        v = '0;
        v[CA_BD_BIT]           = bd;
        v[CA_IP_LSB +: INT_W]  = ip;
        v[CA_EXC_LSB +: EXC_W] = code;
        return v;
    endfunction

endpackage

// File: rtl/cp0_exc_arb.sv
// Combinational exception/interrupt arbitration; interrupts win and record code 0.
module cp0_exc_arb
    import cp0_pkg::*;
(
    input  logic [INT_W-1:0] hw_int_i,
    input  logic [INT_W-1:0] im_i,
    input  logic             ie_i,
    input  logic             exl_i,
    input  logic             valid_i,
    input  logic [EXC_W-1:0] exc_code_i,
    output logic             int_pend_o,
    output logic             exc_pend_o,
    output logic             exc_req_o,
    output logic [EXC_W-1:0] sel_code_o
);

    assign int_pend_o = (|(hw_int_i & im_i)) & ie_i & ~exl_i & valid_i;
    assign exc_pend_o = (exc_code_i != '0) & ~exl_i & valid_i;
    assign exc_req_o  = int_pend_o | exc_pend_o;
    assign sel_code_o = int_pend_o ? EXC_INT : exc_code_i;

endmodule

// File: rtl/cp0.sv
// Coprocessor 0 in the M stage: SR/Cause/EPC/PRId, exception commit,
// mfc0/mtc0 access and eret handling.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [XLEN-1:0] PRID_VALUE = 32'h0000_0007,
    parameter logic [XLEN-1:0] EXC_ENTRY  = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [4:0]       addr,
    input  logic [31:0]      din,
    input  logic [31:0]      pc_m,
    input  logic             pc_m_valid,
    input  logic [6:2]       ExcCode_M,
    input  logic             BD_M,
    input  logic             eret_m,
    input  logic [7:2]       HWInt,
    output logic [31:0]      dout,
    output logic             exc_req,
    output logic [31:0]      exc_entry,
    output logic [31:0]      epc_out,
    output logic             exl_out
);

    logic [INT_W-1:0] sr_im_q, sr_im_d;
    logic             sr_exl_q, sr_exl_d;
    logic             sr_ie_q, sr_ie_d;
    logic             cause_bd_q, cause_bd_d;
    logic [INT_W-1:0] cause_ip_q, cause_ip_d;
    logic [EXC_W-1:0] cause_exc_q, cause_exc_d;
    logic [XLEN-1:0]  epc_q, epc_d;

    logic             int_pend;
    logic             exc_pend;
    logic [EXC_W-1:0] sel_code;
    logic             wr_sr;
    logic             wr_epc;
    logic             unused_pend;
    logic             unused_pc_lsb;

    cp0_exc_arb u_arb (
        .hw_int_i   (HWInt),
        .im_i       (sr_im_q),
        .ie_i       (sr_ie_q),
        .exl_i      (sr_exl_q),
        .valid_i    (pc_m_valid),
        .exc_code_i (ExcCode_M),
        .int_pend_o (int_pend),
        .exc_pend_o (exc_pend),
        .exc_req_o  (exc_req),
        .sel_code_o (sel_code)
    );

    assign unused_pend   = exc_pend;
    assign unused_pc_lsb = ^pc_m[1:0];

    // A committing exception suppresses mtc0 and eret in the same cycle.
    assign wr_sr  = we && (addr == REG_SR)  && !exc_req;
    assign wr_epc = we && (addr == REG_EPC) && !exc_req;

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        cause_ip_d  = HWInt;
        if (exc_req) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = sel_code;
            cause_bd_d  = BD_M;
            epc_d       = BD_M ? {pc_m[31:2] - 30'd1, 2'b00} : {pc_m[31:2], 2'b00};
        end else begin
            if (wr_sr) begin
                sr_im_d  = din[SR_IM_LSB +: INT_W];
                sr_exl_d = din[SR_EXL_BIT];
                sr_ie_d  = din[SR_IE_BIT];
            end
            if (wr_epc) begin
                epc_d = {din[31:2], 2'b00};
            end
            if (eret_m) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            REG_SR:    dout = sr_pack(sr_im_q, sr_exl_q, sr_ie_q);
            REG_CAUSE: dout = cause_pack(cause_bd_q, cause_ip_q, cause_exc_q);
            REG_EPC:   dout = epc_q;
            REG_PRID:  dout = PRID_VALUE;
            default:   dout = '0;
        endcase
    end

    // EPC bypass lets eret directly follow an mtc0 to EPC.
    assign epc_out   = wr_epc ? {din[31:2], 2'b00} : epc_q;
    assign exc_entry = EXC_ENTRY;
    assign exl_out   = sr_exl_q;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: register reads are queued as expectations
// when stimulus is driven and compared when drained from the scoreboard.
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] pc_m;
    logic        pc_m_valid;
    logic [6:2]  ExcCode_M;
    logic        BD_M;
    logic        eret_m;
    logic [7:2]  HWInt;
    logic [31:0] dout;
    logic        exc_req;
    logic [31:0] exc_entry;
    logic [31:0] epc_out;
    logic        exl_out;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] exp;
        string       name;
    } rd_t;

    rd_t sb[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    cp0 dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .pc_m       (pc_m),
        .pc_m_valid (pc_m_valid),
        .ExcCode_M  (ExcCode_M),
        .BD_M       (BD_M),
        .eret_m     (eret_m),
        .HWInt      (HWInt),
        .dout       (dout),
        .exc_req    (exc_req),
        .exc_entry  (exc_entry),
        .epc_out    (epc_out),
        .exl_out    (exl_out)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        we = 1'b0; addr = 5'd0; din = 32'd0; pc_m = 32'd0; pc_m_valid = 1'b0;
        ExcCode_M = 5'd0; BD_M = 1'b0; eret_m = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [4:0] a, input logic [31:0] e, input string n);
        sb.push_back('{a, e, n});
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; din = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rd_t e;
        reset = 1'b0; drive_idle(); HWInt = '0;
        #3;
        n_chk++;
        if (exc_req !== 1'b0) begin n_fail++; $display("FAIL reset_exc_req: got %b want 0", exc_req); end
        n_chk++;
        if (exl_out !== 1'b0) begin n_fail++; $display("FAIL reset_exl: got %b want 0", exl_out); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        cyc();
        n_chk++;
        if (exc_entry !== 32'h0000_4180) begin n_fail++; $display("FAIL exc_entry: got %h want 00004180", exc_entry); end
        push_rd(5'd12, 32'h0, "reset_sr");
        push_rd(5'd13, 32'h0, "reset_cause");
        push_rd(5'd14, 32'h0, "reset_epc");
        push_rd(5'd15, 32'h7, "prid");
        push_rd(5'd3,  32'h0, "unmapped_read");
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; n_chk++;
            if (dout !== e.exp) begin n_fail++; $display("FAIL %s: dout=%h want %h", e.name, dout, e.exp); end
        end
    endtask

    task automatic test_basic_access();
        rd_t e;
        mtc0(5'd12, 32'h0000_FC01);
        push_rd(5'd12, 32'h0000_FC01, "sr_write_read");
        mtc0(5'd13, 32'hFFFF_FFFF);
        push_rd(5'd13, 32'h0, "cause_ignores_write");
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; n_chk++;
            if (dout !== e.exp) begin n_fail++; $display("FAIL %s: dout=%h want %h", e.name, dout, e.exp); end
        end
        mtc0(5'd12, 32'h0);
    endtask

    task automatic test_interrupt();
        rd_t e;
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001; pc_m = 32'h3010; pc_m_valid = 1'b1; BD_M = 1'b0;
        #1; n_chk++;
        if (exc_req !== 1'b1) begin n_fail++; $display("FAIL int_req: got %b want 1", exc_req); end
        cyc(); n_chk++;
        if (exc_req !== 1'b0) begin n_fail++; $display("FAIL int_one_cycle: got %b want 0", exc_req); end
        n_chk++;
        if (exl_out !== 1'b1) begin n_fail++; $display("FAIL int_exl_set: got %b want 1", exl_out); end
        cyc(); n_chk++;
        if (exc_req !== 1'b0) begin n_fail++; $display("FAIL int_masked_held: got %b want 0", exc_req); end
        drive_idle();
        push_rd(5'd13, 32'h0000_0400, "int_cause");
        push_rd(5'd14, 32'h0000_3010, "int_epc");
        push_rd(5'd12, 32'h0000_0403, "int_sr");
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; n_chk++;
            if (dout !== e.exp) begin n_fail++; $display("FAIL %s: dout=%h want %h", e.name, dout, e.exp); end
        end
        HWInt = '0; eret_m = 1'b1;
        cyc(); eret_m = 1'b0; n_chk++;
        if (exl_out !== 1'b0) begin n_fail++; $display("FAIL int_eret_exl: got %b want 0", exl_out); end
    endtask

    task automatic test_sync_delay_slot();
        rd_t e;
        mtc0(5'd12, 32'h0);
        ExcCode_M = 5'd12; BD_M = 1'b1; pc_m = 32'h3024; pc_m_valid = 1'b1;
        #1; n_chk++;
        if (exc_req !== 1'b1) begin n_fail++; $display("FAIL ov_req: got %b want 1", exc_req); end
        cyc(); n_chk++;
        if (exc_req !== 1'b0) begin n_fail++; $display("FAIL ov_no_repeat: got %b want 0", exc_req); end
        drive_idle();
        push_rd(5'd13, 32'h8000_0030, "ov_cause");
        push_rd(5'd14, 32'h0000_3020, "ov_epc_bd");
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; n_chk++;
            if (dout !== e.exp) begin n_fail++; $display("FAIL %s: dout=%h want %h", e.name, dout, e.exp); end
        end
        eret_m = 1'b1; cyc(); eret_m = 1'b0;
    endtask

    task automatic test_int_beats_exc();
        rd_t e;
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001; ExcCode_M = 5'd10; pc_m = 32'h3050; pc_m_valid = 1'b1; BD_M = 1'b0;
        #1; n_chk++;
        if (exc_req !== 1'b1) begin n_fail++; $display("FAIL prio_req: got %b want 1", exc_req); end
        cyc(); drive_idle();
        push_rd(5'd13, 32'h0000_0400, "prio_cause");
        push_rd(5'd14, 32'h0000_3050, "prio_epc");
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; n_chk++;
            if (dout !== e.exp) begin n_fail++; $display("FAIL %s: dout=%h want %h", e.name, dout, e.exp); end
        end
        HWInt = '0; eret_m = 1'b1; cyc(); eret_m = 1'b0;
    endtask

    task automatic test_bubble();
        rd_t e;
        HWInt = 6'b000001; pc_m = 32'h3000; pc_m_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; n_chk++;
            if (exc_req !== 1'b0) begin n_fail++; $display("FAIL bubble_defer%0d: got %b want 0", i, exc_req); end
            cyc();
        end
        pc_m = 32'h3060; pc_m_valid = 1'b1;
        #1; n_chk++;
        if (exc_req !== 1'b1) begin n_fail++; $display("FAIL bubble_take: got %b want 1", exc_req); end
        cyc(); drive_idle();
        push_rd(5'd14, 32'h0000_3060, "bubble_epc");
        push_rd(5'd13, 32'h0000_0400, "bubble_cause");
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; n_chk++;
            if (dout !== e.exp) begin n_fail++; $display("FAIL %s: dout=%h want %h", e.name, dout, e.exp); end
        end
    endtask

    task automatic test_epc_eret();
        rd_t e;
        HWInt = '0;
        we = 1'b1; addr = 5'd14; din = 32'h0000_3041;
        #1; n_chk++;
        if (epc_out !== 32'h0000_3040) begin n_fail++; $display("FAIL epc_bypass: got %h want 00003040", epc_out); end
        cyc(); we = 1'b0; eret_m = 1'b1;
        #1; n_chk++;
        if (epc_out !== 32'h0000_3040) begin n_fail++; $display("FAIL epc_reg: got %h want 00003040", epc_out); end
        n_chk++;
        if (exl_out !== 1'b1) begin n_fail++; $display("FAIL eret_pre_exl: got %b want 1", exl_out); end
        cyc(); eret_m = 1'b0; n_chk++;
        if (exl_out !== 1'b0) begin n_fail++; $display("FAIL eret_exl: got %b want 0", exl_out); end
        mtc0(5'd12, 32'h0000_0803);
        n_chk++;
        if (exl_out !== 1'b1) begin n_fail++; $display("FAIL sr_exl_write: got %b want 1", exl_out); end
        eret_m = 1'b1;
        mtc0(5'd12, 32'h0000_0803);
        eret_m = 1'b0;
        push_rd(5'd12, 32'h0000_0801, "mtc0_sr_with_eret");
        push_rd(5'd14, 32'h0000_3040, "epc_written");
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; n_chk++;
            if (dout !== e.exp) begin n_fail++; $display("FAIL %s: dout=%h want %h", e.name, dout, e.exp); end
        end
    endtask

    task automatic test_suppress_nesting();
        rd_t e;
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001; pc_m = 32'h3070; pc_m_valid = 1'b1; BD_M = 1'b0;
        we = 1'b1; addr = 5'd14; din = 32'hDEAD_BEEF;
        #1; n_chk++;
        if (exc_req !== 1'b1) begin n_fail++; $display("FAIL sup_req: got %b want 1", exc_req); end
        n_chk++;
        if (epc_out !== 32'h0000_3040) begin n_fail++; $display("FAIL sup_no_bypass: got %h want 00003040", epc_out); end
        cyc(); drive_idle();
        ExcCode_M = 5'd4; pc_m = 32'h3080; pc_m_valid = 1'b1;
        #1; n_chk++;
        if (exc_req !== 1'b0) begin n_fail++; $display("FAIL nest_blocked: got %b want 0", exc_req); end
        cyc(); drive_idle();
        push_rd(5'd14, 32'h0000_3070, "sup_epc");
        push_rd(5'd13, 32'h0000_0400, "nest_cause");
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; n_chk++;
            if (dout !== e.exp) begin n_fail++; $display("FAIL %s: dout=%h want %h", e.name, dout, e.exp); end
        end
    endtask

    task automatic test_async_reset();
        rd_t e;
        mtc0(5'd12, 32'h0000_0401);
        pc_m = 32'h3090; pc_m_valid = 1'b1;
        #1; n_chk++;
        if (exc_req !== 1'b1) begin n_fail++; $display("FAIL ar_pre_req: got %b want 1", exc_req); end
        reset = 1'b0;
        #1; n_chk++;
        if (exc_req !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b want 0", exc_req); end
        n_chk++;
        if (exl_out !== 1'b0) begin n_fail++; $display("FAIL ar_exl: got %b want 0", exl_out); end
        drive_idle();
        push_rd(5'd12, 32'h0, "ar_sr");
        push_rd(5'd14, 32'h0, "ar_epc");
        while (sb.size() > 0) begin
            e = sb.pop_front(); addr = e.a; #1; n_chk++;
            if (dout !== e.exp) begin n_fail++; $display("FAIL %s: dout=%h want %h", e.name, dout, e.exp); end
        end
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; HWInt = '0; drive_idle();
        test_reset();
        test_basic_access();
        test_interrupt();
        test_sync_delay_slot();
        test_int_beats_exc();
        test_bubble();
        test_epc_eret();
        test_suppress_nesting();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
